// File: rtl/alu_execute_stage_if.sv
// Execute-stage bus: upstream op handshake plus the registered result/flag return path.
interface alu_execute_stage_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         alu_ctrl;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               flag_z;
  logic               flag_n;
  logic               flag_c;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, shamt, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, shamt, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c
  );
endinterface

// File: rtl/alu_execute_stage.sv
// ALU execute stage: single-cycle logic/arith ops, iterative 1-bit/cycle shifter,
// registered result and Z/N/C flags behind a valid/ready handshake.
module alu_execute_stage #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_execute_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             wr_zn;
    logic             wr_c;
    logic             go_shift;
    logic             shl;
  } exec_t;

  state_t             state;
  logic [WIDTH-1:0]   res_q, work;
  logic [SHAMT_W-1:0] cnt;
  logic               shl_q, fwe_q, ov_q;
  logic               z_q, n_q, c_q;

  exec_t              ex;
  logic               fwe, accept;
  logic [WIDTH-1:0]   shifted;
  logic               out_bit;

  assign bus.in_ready  = rst_n & ((state == IDLE) | ((state == HOLD) & bus.out_ready));
  assign bus.out_valid = ov_q;
  assign bus.result    = res_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign fwe    = bus.alu_ctrl[7];

  // Priority chain: lowest set op bit wins; all-zero op passes op_b through untouched.
  always_comb begin
    ex     = '0;
    ex.res = bus.op_b;
    if (bus.alu_ctrl[0]) begin
      {ex.c, ex.res} = {1'b0, bus.op_a} + {1'b0, bus.op_b};
      ex.wr_zn = fwe;
      ex.wr_c  = fwe;
    end else if (bus.alu_ctrl[1]) begin
      ex.res   = bus.op_a - bus.op_b;
      ex.c     = bus.op_a < bus.op_b;
      ex.wr_zn = fwe;
      ex.wr_c  = fwe;
    end else if (bus.alu_ctrl[2]) begin
      ex.res   = bus.op_a & bus.op_b;
      ex.wr_zn = fwe;
    end else if (bus.alu_ctrl[3]) begin
      ex.res   = bus.op_a | bus.op_b;
      ex.wr_zn = fwe;
    end else if (bus.alu_ctrl[4]) begin
      ex.res   = ~bus.op_a;
      ex.wr_zn = fwe;
    end else if (bus.alu_ctrl[5] | bus.alu_ctrl[6]) begin
      // Zero shift completes like a logic op: passes op_a, leaves C alone.
      ex.res      = bus.op_a;
      ex.wr_zn    = fwe;
      ex.shl      = ~bus.alu_ctrl[5];
      ex.go_shift = (bus.shamt != '0);
    end
  end

  assign shifted = shl_q ? {work[WIDTH-2:0], 1'b0} : {1'b0, work[WIDTH-1:1]};
  assign out_bit = shl_q ? work[WIDTH-1] : work[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      res_q <= '0;
      work  <= '0;
      cnt   <= '0;
      shl_q <= 1'b0;
      fwe_q <= 1'b0;
      ov_q  <= 1'b0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            state <= HOLD;
            ov_q  <= 1'b1;
            res_q <= shifted;
            if (fwe_q) begin
              z_q <= (shifted == '0);
              n_q <= shifted[WIDTH-1];
              c_q <= out_bit;
            end
          end
        end
        default: begin
          if (accept) begin
            if (ex.go_shift) begin
              state <= SHIFT;
              ov_q  <= 1'b0;
              work  <= bus.op_a;
              cnt   <= bus.shamt;
              shl_q <= ex.shl;
              fwe_q <= fwe;
            end else begin
              state <= HOLD;
              ov_q  <= 1'b1;
              res_q <= ex.res;
              if (ex.wr_zn) begin
                z_q <= (ex.res == '0);
                n_q <= ex.res[WIDTH-1];
              end
              if (ex.wr_c) c_q <= ex.c;
            end
          end else if ((state == HOLD) && bus.out_ready) begin
            state <= IDLE;
            ov_q  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Bench for alu_execute_stage: directed plan plus random ops against an arithmetic reference model.
module tb_alu_execute_stage;
  localparam int W  = 16;
  localparam int SW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_execute_stage_if #(.WIDTH(W), .SHAMT_W(SW)) bus();
  alu_execute_stage #(.WIDTH(W), .SHAMT_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   n_vec = 0;
  int   n_err = 0;
  logic mz = 1'b0, mn = 1'b0, mc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-op arithmetic, lowest set bit selects op, flags tracked across ops.
  task automatic model(input logic [7:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] s, output logic [W-1:0] res, output int lat);
    int         op;
    logic [W:0] full;
    logic       c;
    op  = -1;
    for (int i = 6; i >= 0; i--) if (ctrl[i]) op = i;
    lat = 1;
    c   = mc;
    res = b;
    case (op)
      0: begin full = {1'b0, a} + {1'b0, b}; res = full[W-1:0]; c = full[W]; end
      1: begin res = a - b; c = (a < b); end
      2: res = a & b;
      3: res = a | b;
      4: res = ~a;
      5: begin res = a >> s; if (s != 0) begin c = a[s-1]; lat = int'(s) + 1; end end
      6: begin res = a << s; if (s != 0) begin c = a[W-int'(s)]; lat = int'(s) + 1; end end
      default: ;
    endcase
    if (ctrl[7] && op >= 0) begin
      mz = (res == '0);
      mn = res[W-1];
      mc = c;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] ctrl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [SW-1:0] s, input int hold);
    logic [W-1:0] er;
    int           lat, cyc, k;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = ctrl;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.shamt     = s;
    bus.out_ready = (hold == 0);
    #1;
    k = 0;
    while (!bus.in_ready && k < 20) begin @(negedge clk); #1; k++; end
    chk({tag, " accept"}, 32'(bus.in_ready), 32'd1);
    model(ctrl, a, b, s, er, lat);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 8'($urandom);
    bus.op_a     = W'($urandom);
    bus.op_b     = W'($urandom);
    bus.shamt    = SW'($urandom);
    #1;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      chk({tag, " busy_in_ready"}, 32'(bus.in_ready), 32'd0);
      @(negedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " result"}, 32'(bus.result), 32'(er));
    chk({tag, " flags"}, {29'd0, bus.flag_z, bus.flag_n, bus.flag_c}, {29'd0, mz, mn, mc});
    repeat (hold) begin
      @(negedge clk); #1;
      chk({tag, " hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " hold_result"}, 32'(bus.result), 32'(er));
      chk({tag, " hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    chk({tag, " drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] er[4];
    logic [2:0]   ef[4];
    logic [W-1:0] ra, rb, rres;
    logic [7:0]   rc;
    logic [SW-1:0] rs;
    int           rlat;

    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.shamt     = '0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst result", 32'(bus.result), 32'd0);
    chk("rst flags", {29'd0, bus.flag_z, bus.flag_n, bus.flag_c}, 32'd0);
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("idle in_ready", 32'(bus.in_ready), 32'd1);

    // Directed plan
    do_op("add_wrap", 8'h81, 16'hFFFF, 16'h0001, 4'd0, 0);
    do_op("sub_borrow", 8'h82, 16'd3, 16'd5, 4'd0, 0);
    do_op("and_nofwe", 8'h04, 16'd0, 16'd0, 4'd0, 0);
    do_op("shl3", 8'hC0, 16'h8001, 16'h0, 4'd3, 0);
    do_op("shl1", 8'hC0, 16'h8001, 16'h0, 4'd1, 0);
    do_op("shr0_hold", 8'hA0, 16'h0001, 16'h5555, 4'd0, 5);
    do_op("nop_passb", 8'h80, 16'h1111, 16'hBEEF, 4'd0, 0);
    do_op("multi_bit", 8'h8C, 16'h00F0, 16'h0F0F, 4'd0, 0);

    // Back-to-back stream: one accept and one result per cycle
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        ra = W'($urandom); rb = W'($urandom);
        bus.in_valid = 1'b1; bus.alu_ctrl = 8'h81; bus.op_a = ra; bus.op_b = rb; bus.shamt = '0;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (k < 4) chk("stream in_ready", 32'(bus.in_ready), 32'd1);
      if (k > 0) begin
        chk("stream valid", 32'(bus.out_valid), 32'd1);
        chk("stream result", 32'(bus.result), 32'(er[k-1]));
        chk("stream flags", {29'd0, bus.flag_z, bus.flag_n, bus.flag_c}, {29'd0, ef[k-1]});
      end
      if (k < 4) begin
        model(8'h81, ra, rb, '0, er[k], rlat);
        ef[k] = {mz, mn, mc};
      end
      @(negedge clk);
    end
    #1;
    chk("stream drained", 32'(bus.out_valid), 32'd0);

    // Async reset in the middle of a long shift
    do_op("pre_rst_sub", 8'h82, 16'd1, 16'd2, 4'd0, 0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_ctrl = 8'hC0; bus.op_a = 16'hA5A5; bus.shamt = 4'd15;
    #1;
    chk("long_shl accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst result", 32'(bus.result), 32'd0);
    chk("midrst flags", {29'd0, bus.flag_z, bus.flag_n, bus.flag_c}, 32'd0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'd0);
    mz = 1'b0; mn = 1'b0; mc = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_op("post_rst_add", 8'h81, 16'd2, 16'd2, 4'd0, 0);

    // Random ops: one-hot, multi-bit and empty op fields, random fwe, shamt and backpressure
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0:       rc = 8'h00;
        1:       rc = 8'($urandom_range(1, 127));
        default: rc = 8'(1 << $urandom_range(0, 6));
      endcase
      rc[7] = 1'($urandom_range(0, 1));
      rs    = ($urandom_range(0, 3) == 0) ? SW'(0) : SW'($urandom);
      do_op("rand", rc, W'($urandom), W'($urandom), rs, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
